// File: rtl/float_to_fixed_pipe.sv
// Three-stage IEEE-754 single to signed fixed-point converter with valid/ready flow
// control, truncate / round-half-away rounding, saturation and sticky exception flags.
module float_to_fixed_pipe #(
    parameter int TOTAL_BITS      = 32,
    parameter int FRACTIONAL_BITS = 20,
    parameter int STICKY_FLAGS    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_float,
    input  logic                  in_round,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TOTAL_BITS-1:0] out_fixed,
    output logic                  out_ovf,
    output logic                  out_nan,
    output logic                  out_unf,
    output logic                  sticky_ovf,
    output logic                  sticky_nan,
    input  logic                  sticky_clr
);

    // Magnitude width holds a 24-bit significand shifted left by up to TOTAL_BITS.
    localparam int MW = TOTAL_BITS + 25;

    localparam logic [2:0] CLS_NORM = 3'd0;
    localparam logic [2:0] CLS_ZERO = 3'd1;
    localparam logic [2:0] CLS_SUB  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    localparam logic signed [10:0]  SH_MAX  = 11'(TOTAL_BITS);
    localparam logic [MW-1:0]       LIM_NEG = MW'(1'b1) << (TOTAL_BITS - 1);
    localparam logic [MW-1:0]       LIM_POS = LIM_NEG - MW'(1'b1);
    localparam logic [TOTAL_BITS-1:0] SAT_POS = {1'b0, {(TOTAL_BITS-1){1'b1}}};
    localparam logic [TOTAL_BITS-1:0] SAT_NEG = {1'b1, {(TOTAL_BITS-1){1'b0}}};

    logic                   advance_s;
    logic [2:0]             s1_cls_d, s1_cls_q, s2_cls_q;
    logic signed [10:0]     s1_sh_d, s1_sh_q;
    logic                   s1_valid_q, s1_sign_q, s1_round_q;
    logic [23:0]            s1_sig_q;
    logic [10:0]            rs_s;
    logic [23:0]            shr_s;
    logic                   rbit_s;
    logic [MW-1:0]          s2_mag_d, s2_mag_q;
    logic                   s2_huge_d, s2_huge_q, s2_valid_q, s2_sign_q;
    logic [TOTAL_BITS-1:0]  out_fixed_d, out_fixed_q;
    logic                   ovf_d, nan_d, unf_d;
    logic                   out_valid_q, ovf_q, nan_q, unf_q;

    assign advance_s = !out_valid_q || out_ready;
    assign in_ready  = advance_s;

    // Stage 1 classification and unbiased shift amount.
    always_comb begin
        s1_cls_d = CLS_NORM;
        s1_sh_d  = 11'(in_float[30:23]) - 11'd150 + 11'(FRACTIONAL_BITS);
        if (in_float[30:23] == 8'd0) begin
            s1_cls_d = (in_float[22:0] == 23'd0) ? CLS_ZERO : CLS_SUB;
        end else if (in_float[30:23] == 8'hFF) begin
            s1_cls_d = (in_float[22:0] == 23'd0) ? CLS_INF : CLS_NAN;
        end else begin
            s1_cls_d = CLS_NORM;
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_round_q <= 1'b0;
            s1_cls_q   <= CLS_ZERO;
            s1_sh_q    <= 11'sd0;
            s1_sig_q   <= 24'd0;
        end else if (advance_s) begin
            s1_valid_q <= in_valid;
            s1_sign_q  <= in_float[31];
            s1_round_q <= in_round;
            s1_cls_q   <= s1_cls_d;
            s1_sh_q    <= s1_sh_d;
            s1_sig_q   <= {1'b1, in_float[22:0]};
        end
    end

    // Stage 2 alignment; right shifts round on the first discarded bit.
    always_comb begin
        s2_mag_d  = '0;
        s2_huge_d = 1'b0;
        rs_s      = -s1_sh_q;
        shr_s     = 24'd0;
        rbit_s    = 1'b0;
        if (s1_cls_q != CLS_NORM) begin
            s2_mag_d = '0;
        end else if (s1_sh_q > SH_MAX) begin
            s2_huge_d = 1'b1;
        end else if (s1_sh_q >= 11'sd0) begin
            s2_mag_d = {{(MW-24){1'b0}}, s1_sig_q} << s1_sh_q[5:0];
        end else if (rs_s >= 11'd25) begin
            s2_mag_d = '0;
        end else begin
            shr_s    = s1_sig_q >> rs_s[4:0];
            rbit_s   = s1_sig_q[rs_s[4:0] - 5'd1];
            s2_mag_d = MW'(shr_s) + MW'(s1_round_q & rbit_s);
        end
    end

    // Stage 2 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_cls_q   <= CLS_ZERO;
            s2_mag_q   <= '0;
            s2_huge_q  <= 1'b0;
        end else if (advance_s) begin
            s2_valid_q <= s1_valid_q;
            s2_sign_q  <= s1_sign_q;
            s2_cls_q   <= s1_cls_q;
            s2_mag_q   <= s2_mag_d;
            s2_huge_q  <= s2_huge_d;
        end
    end

    // Stage 3 sign application, saturation and flag selection.
    always_comb begin
        out_fixed_d = '0;
        ovf_d       = 1'b0;
        nan_d       = 1'b0;
        unf_d       = 1'b0;
        if (s2_valid_q) begin
            case (s2_cls_q)
                CLS_NAN: nan_d = 1'b1;
                CLS_SUB: unf_d = 1'b1;
                CLS_INF: begin
                    ovf_d       = 1'b1;
                    out_fixed_d = s2_sign_q ? SAT_NEG : SAT_POS;
                end
                CLS_NORM: begin
                    if (s2_huge_q || (s2_sign_q ? (s2_mag_q > LIM_NEG) : (s2_mag_q > LIM_POS))) begin
                        ovf_d       = 1'b1;
                        out_fixed_d = s2_sign_q ? SAT_NEG : SAT_POS;
                    end else if (s2_mag_q == '0) begin
                        unf_d = 1'b1;
                    end else if (s2_sign_q) begin
                        out_fixed_d = -s2_mag_q[TOTAL_BITS-1:0];
                    end else begin
                        out_fixed_d = s2_mag_q[TOTAL_BITS-1:0];
                    end
                end
                default: out_fixed_d = '0;
            endcase
        end else begin
            out_fixed_d = '0;
        end
    end

    // Output register; holds while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_fixed_q <= '0;
            ovf_q       <= 1'b0;
            nan_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else if (advance_s) begin
            out_valid_q <= s2_valid_q;
            out_fixed_q <= out_fixed_d;
            ovf_q       <= ovf_d;
            nan_q       <= nan_d;
            unf_q       <= unf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fixed = out_fixed_q;
    assign out_ovf   = ovf_q;
    assign out_nan   = nan_q;
    assign out_unf   = unf_q;

    generate
        if (STICKY_FLAGS != 0) begin : g_sticky
            logic sticky_ovf_q, sticky_nan_q;

            // Sticky accumulation on output transfers; clear wins over a same-cycle set.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sticky_ovf_q <= 1'b0;
                    sticky_nan_q <= 1'b0;
                end else if (sticky_clr) begin
                    sticky_ovf_q <= 1'b0;
                    sticky_nan_q <= 1'b0;
                end else if (out_valid_q && out_ready) begin
                    sticky_ovf_q <= sticky_ovf_q | ovf_q;
                    sticky_nan_q <= sticky_nan_q | nan_q;
                end
            end

            assign sticky_ovf = sticky_ovf_q;
            assign sticky_nan = sticky_nan_q;
        end else begin : g_no_sticky
            assign sticky_ovf = 1'b0;
            assign sticky_nan = 1'b0;
        end
    endgenerate

endmodule
